// File: rtl/avgiq_pkg.sv
// Shared definitions for the IQ-averaging capture sequencer: FSM states,
// control-word bit positions and the default maximum log2 averaging length.
package avgiq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StAccum,
    StDone
  } state_e;

  // Bit positions inside the software control word.
  localparam int unsigned START_BIT = 0;
  localparam int unsigned ABORT_BIT = 1;
  localparam int unsigned L_LSB     = 2;
  localparam int unsigned L_MSB     = 5;
  localparam int unsigned CH_LSB    = 8;

  // Largest supported log2 averaging length; larger requests clamp to this.
  localparam int unsigned LMAX = 12;

endpackage

// File: rtl/avgiq_capture_ctrl_if.sv
// Sample-stream input and BRAM write port of the avgIQ capture sequencer.
// master: stream source / BRAM sink side. slave: the capture sequencer.
interface avgiq_capture_ctrl_if #(
  parameter int unsigned DW  = 16,
  parameter int unsigned CHW = 8,
  parameter int unsigned AW  = 10
);

  logic                 in_sync;
  logic                 in_valid;
  logic [CHW-1:0]       in_chan;
  logic signed [DW-1:0] in_i;
  logic signed [DW-1:0] in_q;

  logic                 bram_we;
  logic [AW-1:0]        bram_addr;
  logic [2*DW-1:0]      bram_data;

  modport master (
    output in_sync, in_valid, in_chan, in_i, in_q,
    input  bram_we, bram_addr, bram_data
  );

  modport slave (
    input  in_sync, in_valid, in_chan, in_i, in_q,
    output bram_we, bram_addr, bram_data
  );

endinterface

// File: rtl/avgiq_accum.sv
// One signed averaging accumulator: clear (priority), add, and a combinational
// average of (accumulator + current sample) >>> shift.
// Build option: define AVGIQ_ROUND_EN for round-half-up instead of floor.
module avgiq_accum #(
  parameter int unsigned DW   = 16,
  parameter int unsigned LMAX = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 add_i,
  input  logic signed [DW-1:0] smp_i,
  input  logic [3:0]           shift_i,
  output logic signed [DW-1:0] avg_o
);

  localparam int unsigned AccW = DW + LMAX;

  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [AccW:0]   rnd;
  logic signed [AccW:0]   sum;
  logic signed [AccW:0]   shifted;
  logic                   unused_hi;

  // Next accumulator value; clear wins so the last sample of a point restarts at zero.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + AccW'(smp_i);
    end
  end

  // Average including the sample presented this cycle.
  always_comb begin
    rnd = '0;
`ifdef AVGIQ_ROUND_EN
    if (shift_i != 4'd0) begin
      rnd = (AccW + 1)'(1) << (shift_i - 4'd1);
    end
`endif
    sum     = (AccW + 1)'(acc_q) + (AccW + 1)'(smp_i) + rnd;
    shifted = sum >>> shift_i;
    avg_o   = shifted[DW-1:0];
  end

  assign unused_hi = ^shifted[AccW:DW];

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/avgiq_capture_ctrl.sv
// avgIQ capture sequencer: selects one channel of the time-multiplexed I/Q
// stream, averages 2^L samples per point and writes N_PTS points to BRAM.
// Build option: AVGIQ_ROUND_EN (round-half-up averaging, see avgiq_accum).
module avgiq_capture_ctrl #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CHW   = 8,
  parameter int unsigned AW    = 10,
  parameter int unsigned N_PTS = 1024,
  parameter int unsigned LMAX  = avgiq_pkg::LMAX
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic [31:0]         ctrl_word,
  avgiq_capture_ctrl_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic [AW:0]         pt_count
);

  import avgiq_pkg::*;

  logic [31:0]          ctrl_q;
  state_e               state_q, state_d;
  logic [3:0]           l_q;
  logic [CHW-1:0]       chan_q;
  logic [LMAX-1:0]      cnt_q;
  logic [AW:0]          pt_count_q;
  logic                 bram_we_q;
  logic [AW-1:0]        bram_addr_q;
  logic [2*DW-1:0]      bram_data_q;

  logic                 start_edge;
  logic                 abort;
  logic [3:0]           l_req;
  logic [3:0]           l_clamp;
  logic                 chan_match;
  logic [LMAX:0]        pt_len;
  logic                 accept;
  logic                 start_cap;
  logic                 last_smp;
  logic                 acc_clr;
  logic signed [DW-1:0] avg_i, avg_q;
  logic                 unused_ctrl;

  assign unused_ctrl = ^ctrl_q[31:1];

  // Control-word decode and per-capture derived values.
  always_comb begin
    start_edge = ctrl_word[START_BIT] & ~ctrl_q[START_BIT];
    abort      = ctrl_word[ABORT_BIT];
    l_req      = ctrl_word[L_MSB:L_LSB];
    l_clamp    = (32'(l_req) > LMAX) ? 4'(LMAX) : l_req;
    chan_match = (bus.in_chan == chan_q);
    pt_len     = (LMAX + 1)'(1) << l_q;
  end

  // Next state and accept decision; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    start_cap = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_edge) begin
          state_d   = StArm;
          start_cap = 1'b1;
        end
      end
      StArm: begin
        if (bus.in_valid && bus.in_sync) begin
          state_d = StAccum;
          accept  = chan_match;
        end
      end
      StAccum: begin
        // Final write is already out; move on the cycle after it.
        if (pt_count_q == (AW + 1)'(N_PTS)) begin
          state_d = StDone;
        end else begin
          accept = bus.in_valid & chan_match;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d   = StIdle;
      accept    = 1'b0;
      start_cap = 1'b0;
    end
    last_smp = accept & (cnt_q == LMAX'(pt_len - 1'b1));
    acc_clr  = start_cap | abort | last_smp;
  end

  // Control register, state register and shadow settings.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ctrl_q  <= '0;
      state_q <= StIdle;
      l_q     <= '0;
      chan_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_word;
      state_q <= state_d;
      if (start_cap) begin
        l_q    <= l_clamp;
        chan_q <= ctrl_word[CH_LSB +: CHW];
      end
    end
  end

  // Sample-in-point counter and written-point counter.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      cnt_q      <= '0;
      pt_count_q <= '0;
    end else begin
      if (acc_clr) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (start_cap) begin
        pt_count_q <= '0;
      end else if (last_smp) begin
        pt_count_q <= pt_count_q + 1'b1;
      end
    end
  end

  // BRAM write register: one-cycle strobe after the last sample of a point.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
    end else begin
      bram_we_q <= last_smp;
      if (last_smp) begin
        bram_addr_q <= pt_count_q[AW-1:0];
        bram_data_q <= {avg_i, avg_q};
      end
    end
  end

  avgiq_accum #(
    .DW   (DW),
    .LMAX (LMAX)
  ) u_acc_i (
    .clk_i   (user_clk),
    .rst_ni  (user_rst_n),
    .clr_i   (acc_clr),
    .add_i   (accept),
    .smp_i   (bus.in_i),
    .shift_i (l_q),
    .avg_o   (avg_i)
  );

  avgiq_accum #(
    .DW   (DW),
    .LMAX (LMAX)
  ) u_acc_q (
    .clk_i   (user_clk),
    .rst_ni  (user_rst_n),
    .clr_i   (acc_clr),
    .add_i   (accept),
    .smp_i   (bus.in_q),
    .shift_i (l_q),
    .avg_o   (avg_q)
  );

  assign bus.bram_we   = bram_we_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_data = bram_data_q;
  assign busy          = (state_q == StArm) || (state_q == StAccum);
  assign done          = (state_q == StDone);
  assign pt_count      = pt_count_q;

endmodule

// File: tb/tb_avgiq_capture_ctrl.sv
// Self-checking bench for avgiq_capture_ctrl: lockstep reference model built
// from sample queues and integer division, a rounding vector table and
// directed multi-cycle sequences (abort, restart, clamp, reset).
module tb_avgiq_capture_ctrl;

  localparam int unsigned DW  = 16;
  localparam int unsigned CHW = 8;
  localparam int unsigned AW  = 10;
  localparam int unsigned NP  = 4;
  localparam int unsigned LMX = 12;

  logic          user_clk = 1'b0;
  logic          user_rst_n;
  logic [31:0]   ctrl_word;
  logic          busy, done;
  logic [AW:0]   pt_count;

  avgiq_capture_ctrl_if #(.DW(DW), .CHW(CHW), .AW(AW)) bus ();

  avgiq_capture_ctrl #(
    .DW(DW), .CHW(CHW), .AW(AW), .N_PTS(NP), .LMAX(LMX)
  ) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .ctrl_word  (ctrl_word),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .pt_count   (pt_count)
  );

  always #5 user_clk = ~user_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int m_phase;  // 0 idle, 1 armed, 2 capturing, 3 complete
  bit m_prev_start, m_fin, m_we;
  int m_l, m_ch, m_pt, m_addr, m_di, m_dq;
  int q_i[$];
  int q_q[$];
  int n_wr, obs_addr, obs_i, obs_q;

  task automatic model_reset();
    m_phase = 0; m_prev_start = 0; m_fin = 0; m_we = 0;
    m_l = 0; m_ch = 0; m_pt = 0; m_addr = 0; m_di = 0; m_dq = 0;
    q_i.delete(); q_q.delete();
  endtask

  function automatic int avg_of(int s[$], int l);
    int sum = 0;
    int d = 1 << l;
    foreach (s[k]) sum += s[k];
`ifdef AVGIQ_ROUND_EN
    if (l > 0) sum += d / 2;
`endif
    if (sum >= 0) return sum / d;
    return -((-sum + d - 1) / d);
  endfunction

  task automatic take();
    q_i.push_back(int'(bus.in_i));
    q_q.push_back(int'(bus.in_q));
    if (q_i.size() == (1 << m_l)) begin
      m_we = 1; m_addr = m_pt;
      m_di = avg_of(q_i, m_l); m_dq = avg_of(q_q, m_l);
      m_pt++;
      q_i.delete(); q_q.delete();
      if (m_pt == NP) m_fin = 1;
    end
  endtask

  // Predicts what the coming clock edge does with the inputs now applied.
  task automatic model_step();
    bit st, ab;
    int l;
    st = ctrl_word[0] && !m_prev_start;
    ab = ctrl_word[1];
    m_prev_start = ctrl_word[0];
    m_we = 0;
    if (ab) begin
      m_phase = 0; m_fin = 0; q_i.delete(); q_q.delete();
    end else if (m_phase == 0 || m_phase == 3) begin
      if (st) begin
        m_phase = 1; m_fin = 0;
        l = int'(ctrl_word[5:2]);
        m_l = (l > 12) ? 12 : l;
        m_ch = int'(ctrl_word[15:8]);
        m_pt = 0; q_i.delete(); q_q.delete();
      end
    end else if (m_phase == 1) begin
      if (bus.in_valid && bus.in_sync) begin
        m_phase = 2;
        if (int'(bus.in_chan) == m_ch) take();
      end
    end else begin
      if (m_fin) begin
        m_phase = 3; m_fin = 0;
      end else if (bus.in_valid && int'(bus.in_chan) == m_ch) begin
        take();
      end
    end
  endtask

  task automatic check_cycle();
    chk("bram_we", bus.bram_we, m_we);
    if (m_we) begin
      chk("bram_addr", bus.bram_addr, m_addr);
      chk("avg_i", int'($signed(bus.bram_data[2*DW-1:DW])), m_di);
      chk("avg_q", int'($signed(bus.bram_data[DW-1:0])), m_dq);
    end
    chk("busy", busy, (m_phase == 1 || m_phase == 2));
    chk("done", done, (m_phase == 3));
    chk("pt_count", pt_count, m_pt);
    if (bus.bram_we) begin
      n_wr++;
      obs_addr = int'(bus.bram_addr);
      obs_i = int'($signed(bus.bram_data[2*DW-1:DW]));
      obs_q = int'($signed(bus.bram_data[DW-1:0]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge user_clk);
    #1;
    check_cycle();
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] cw(int l, int ch, bit st, bit ab);
    return (32'(ch) << 8) | (32'(l) << 2) | {30'b0, ab, st};
  endfunction

  task automatic set_in(bit v, bit s, int ch, int i, int q);
    bus.in_valid = v; bus.in_sync = s; bus.in_chan = CHW'(ch);
    bus.in_i = DW'(i); bus.in_q = DW'(q);
  endtask

  task automatic start_cap(int l, int ch);
    ctrl_word = cw(l, ch, 0, 0);
    set_in(0, 0, 0, 0, 0);
    tick();
    ctrl_word = cw(l, ch, 1, 0);
    tick();
  endtask

  task automatic do_abort();
    ctrl_word = 32'h2;
    set_in(0, 0, 0, 0, 0);
    tick();
    ctrl_word = 32'h0;
    tick();
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_we"}, bus.bram_we, 0);
    chk({tag, "_addr"}, bus.bram_addr, 0);
    chk({tag, "_data"}, bus.bram_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ptcnt"}, pt_count, 0);
  endtask

  // ---------------- rounding vector table ----------------
  typedef struct packed {
    logic [3:0]           l;
    logic [3:0][DW-1:0]   si;
    logic [3:0][DW-1:0]   sq;
    logic signed [DW-1:0] ei;
    logic signed [DW-1:0] eq;
  } vec_t;

  function automatic vec_t mk(int l, int i0, int i1, int i2, int i3,
                              int q0, int q1, int q2, int q3, int ei, int eq);
    vec_t v;
    v.l = 4'(l);
    v.si[0] = DW'(i0); v.si[1] = DW'(i1); v.si[2] = DW'(i2); v.si[3] = DW'(i3);
    v.sq[0] = DW'(q0); v.sq[1] = DW'(q1); v.sq[2] = DW'(q2); v.sq[3] = DW'(q3);
    v.ei = DW'(ei); v.eq = DW'(eq);
    return v;
  endfunction

  vec_t tbl[4];

  initial begin
    int k, acc_n, last_v, tog;
    logic st_bit;

`ifdef AVGIQ_ROUND_EN
    tbl[0] = mk(1, 1, 2, 0, 0, -1, -2, 0, 0, 2, -1);
    tbl[1] = mk(1, 5, 6, 0, 0, -5, -6, 0, 0, 6, -5);
    tbl[2] = mk(0, 7, 0, 0, 0, -3, 0, 0, 0, 7, -3);
    tbl[3] = mk(2, 1, 1, 1, 0, -1, -1, -1, -1, 1, -1);
`else
    tbl[0] = mk(1, 1, 2, 0, 0, -1, -2, 0, 0, 1, -2);
    tbl[1] = mk(1, 5, 6, 0, 0, -5, -6, 0, 0, 5, -6);
    tbl[2] = mk(0, 7, 0, 0, 0, -3, 0, 0, 0, 7, -3);
    tbl[3] = mk(2, 1, 1, 1, 0, -1, -1, -1, -1, 0, -1);
`endif

    ctrl_word = '0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    n_wr = 0; obs_addr = 0; obs_i = 0; obs_q = 0;
    user_rst_n = 1'b1;
    #1 user_rst_n = 1'b0;
    #10;
    check_all_zero("reset");
    user_rst_n = 1'b1;

    // Basic capture: L=2, channel 5 of 8, I=4,8,12,16 repeating, Q=-4.
    start_cap(2, 5);
    n_wr = 0; k = 0;
    for (int f = 0; f < 20 && !done; f++) begin
      for (int c = 0; c < 8; c++) begin
        if (c == 5) begin
          set_in(1, 0, 5, 4 * ((k % 4) + 1), -4);
          k++;
        end else begin
          set_in(1, c == 0, c, int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 50)));
        end
        tick();
      end
    end
    chk("basic_done", done, 1);
    chk("basic_writes", n_wr, 4);
    chk("basic_last_addr", obs_addr, 3);
    chk("basic_avg_i", obs_i, 10);
    chk("basic_avg_q", obs_q, -4);

    // Rounding / truncation table, first point only.
    for (int t = 0; t < 4; t++) begin
      start_cap(int'(tbl[t].l), 6);
      n_wr = 0;
      for (int s = 0; s < (1 << int'(tbl[t].l)); s++) begin
        set_in(1, s == 0, 6, int'($signed(tbl[t].si[s])), int'($signed(tbl[t].sq[s])));
        tick();
      end
      chk("tbl_writes", n_wr, 1);
      chk("tbl_avg_i", obs_i, int'(tbl[t].ei));
      chk("tbl_avg_q", obs_q, int'(tbl[t].eq));
      do_abort();
    end

    // L=15 clamps to 12: first write after exactly 4096 accepts.
    start_cap(15, 1);
    n_wr = 0; acc_n = -1;
    for (int j = 0; j < 5000; j++) begin
      set_in(1, j == 0, 1, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 300)));
      tick();
      if (n_wr > 0) begin
        acc_n = j + 1;
        break;
      end
    end
    chk("clamp_accepts", acc_n, 4096);
    do_abort();

    // L=0: every matching sample written unchanged.
    start_cap(0, 2);
    n_wr = 0; last_v = 0;
    for (int f = 0; f < 10 && !done; f++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 2) begin
          last_v = int'($urandom_range(0, 60000)) - 30000;
          set_in(1, 0, 2, last_v, -last_v);
        end else begin
          set_in(1, c == 0, c, 99, 99);
        end
        tick();
      end
    end
    chk("l0_writes", n_wr, 4);
    chk("l0_done", done, 1);
    chk("l0_passthru", obs_i, last_v);

    // Abort after two points, then a fresh start writes from addr 0.
    start_cap(1, 2);
    n_wr = 0;
    for (int j = 0; j < 20 && n_wr < 2; j++) begin
      set_in(1, j == 0, 2, j * 3, -j);
      tick();
    end
    ctrl_word = cw(1, 2, 0, 1);
    for (int j = 0; j < 6; j++) begin
      set_in(1, j == 1, 2, 17, 17);
      tick();
    end
    chk("abort_writes", n_wr, 2);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ptcnt", pt_count, 2);
    start_cap(1, 2);
    n_wr = 0;
    for (int j = 0; j < 20 && n_wr < 1; j++) begin
      set_in(1, j == 0, 2, 100 + j, j);
      tick();
    end
    chk("restart_addr", obs_addr, 0);
    for (int j = 0; j < 30 && !done; j++) begin
      set_in(1, 0, 2, j, j);
      tick();
    end
    chk("restart_writes", n_wr, 4);

    // Start toggling during capture is ignored.
    start_cap(1, 3);
    n_wr = 0; tog = 0;
    for (int j = 0; j < 60 && !done; j++) begin
      st_bit = ((j / 3) % 2) == 0;
      ctrl_word = cw(1, 3, st_bit, 0);
      set_in(j % 2 == 0, j == 0, 3, j * 5 - 40, 7 - j);
      tick();
      tog++;
    end
    chk("toggle_done", done, 1);
    chk("toggle_writes", n_wr, 4);

    // Randomized captures with stray starts and occasional aborts.
    for (int r = 0; r < 6; r++) begin
      int rl, rch;
      rl = int'($urandom_range(0, 3));
      rch = int'($urandom_range(0, 3));
      start_cap(rl, rch);
      st_bit = 1'b1;
      for (int j = 0; j < 300; j++) begin
        if ($urandom_range(0, 9) == 0) st_bit = ~st_bit;
        ctrl_word = cw(rl, rch, st_bit, $urandom_range(0, 149) == 0);
        set_in($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768);
        tick();
      end
      do_abort();
    end

    // Asynchronous reset mid-capture, then a clean capture.
    start_cap(2, 4);
    for (int j = 0; j < 10; j++) begin
      set_in(1, j == 0, 4, j + 1, -j);
      tick();
    end
    #2 user_rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    ctrl_word = '0;
    set_in(0, 0, 0, 0, 0);
    #10 user_rst_n = 1'b1;
    start_cap(2, 4);
    n_wr = 0;
    for (int j = 0; j < 40 && !done; j++) begin
      set_in(1, j == 0, 4, 8, -8);
      tick();
    end
    chk("post_rst_writes", n_wr, 4);
    chk("post_rst_done", done, 1);
    chk("post_rst_avg", obs_i, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
